// File: rtl/lowpass_frame_tx_if.sv
// Host/filter-side bundle for the low-pass frame transmitter.
// The master modport belongs to whoever drives the frame (host and filter
// return signals); the slave modport is the transmitter itself.
interface lowpass_frame_tx_if #(
  parameter int ADDR_W = 18,
  parameter int SIZE   = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE-1:0]   wr_data;
  logic              start;
  logic              pix_ready;
  logic              filt_finish;
  logic [SIZE-1:0]   pix_out;
  logic              pix_valid;
  logic              proc_en;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, pix_ready, filt_finish,
    input  pix_out, pix_valid, proc_en, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, pix_ready, filt_finish,
    output pix_out, pix_valid, proc_en, busy, done
  );
endinterface

// File: rtl/lowpass_frame_tx.sv
// Frame transmitter feeding the low-pass filter: buffers one greyscale frame
// written by the host, streams it column-major as the filter's pixel stream,
// then holds the filter's process enable until it reports finish.
module lowpass_frame_tx #(
  parameter int WIDTH  = 361,
  parameter int DEPTH  = 410,
  parameter int SIZE   = 8,
  parameter int ADDR_W = 18
) (
  input logic               clk,
  input logic               rst_n,
  lowpass_frame_tx_if.slave bus
);

  localparam int NPIX   = WIDTH * DEPTH;
  localparam int MEM_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W  = $clog2(WIDTH + 1);
  localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, PROCESS, DONE} state_t;

  state_t           state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [SIZE-1:0]  pix_out_reg;
  logic             pix_valid_reg;
  logic             proc_en_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [SIZE-1:0]  mem [0:NPIX-1];

  // One extra bit so that the index just past the frame (col == WIDTH)
  // never wraps back into range, even when NPIX == 2**ADDR_W.
  logic [ADDR_W:0]  rd_lin;
  logic [SIZE-1:0]  rd_pix;
  logic             pix_left;
  logic             fetch;
  logic             last_row;
  logic             wr_ok;

  assign rd_lin   = (ADDR_W + 1)'(col_reg) * (ADDR_W + 1)'(DEPTH) + (ADDR_W + 1)'(row_reg);
  assign pix_left = (rd_lin < (ADDR_W + 1)'(NPIX));
  assign rd_pix   = mem[rd_lin[MEM_AW-1:0]];
  assign last_row = (row_reg == ROW_W'(DEPTH - 1));

  // A new pixel may be presented when the output slot is empty or being
  // accepted this cycle, and the frame is not yet exhausted.
  assign fetch = (state_reg == SEND) && (!pix_valid_reg || bus.pix_ready) && pix_left;

  // The buffer is only writable while nothing is being transmitted, and
  // addresses beyond the frame are dropped rather than aliased.
  assign wr_ok = bus.wr_en
              && ((state_reg == IDLE) || (state_reg == DONE))
              && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(NPIX));

  // Frame buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.wr_addr[MEM_AW-1:0]] <= bus.wr_data;
    end
  end

  // Transmit FSM with registered outputs and column-major pixel counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      col_reg       <= '0;
      row_reg       <= '0;
      pix_out_reg   <= '0;
      pix_valid_reg <= 1'b0;
      proc_en_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            col_reg   <= '0;
            row_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (fetch) begin
            pix_out_reg   <= rd_pix;
            pix_valid_reg <= 1'b1;
            if (last_row) begin
              row_reg <= '0;
              col_reg <= col_reg + COL_W'(1);
            end else begin
              row_reg <= row_reg + ROW_W'(1);
            end
          end else if (!pix_left && pix_valid_reg && bus.pix_ready) begin
            // Last pixel accepted: hand over to the filter's processing phase.
            pix_valid_reg <= 1'b0;
            proc_en_reg   <= 1'b1;
            state_reg     <= PROCESS;
          end
        end
        PROCESS: begin
          if (bus.filt_finish) begin
            proc_en_reg <= 1'b0;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (bus.start) begin
            col_reg   <= '0;
            row_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= SEND;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pix_out   = pix_out_reg;
  assign bus.pix_valid = pix_valid_reg;
  assign bus.proc_en   = proc_en_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_lowpass_frame_tx.sv
// Directed bench for lowpass_frame_tx on a 3x4 frame: expected pixels are
// queued when a frame is started and compared as the DUT hands them over.
module tb_lowpass_frame_tx;

  localparam int WIDTH  = 3;
  localparam int DEPTH  = 4;
  localparam int SIZE   = 8;
  localparam int ADDR_W = 5;
  localparam int NPIX   = WIDTH * DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic [SIZE-1:0] exp_q[$];

  lowpass_frame_tx_if #(.ADDR_W(ADDR_W), .SIZE(SIZE)) bus ();

  lowpass_frame_tx #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SIZE  (SIZE),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(i + 10));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_out"},   32'(bus.pix_out),   0);
    check({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
    check({tag, "_proc_en"},   32'(bus.proc_en),   0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
  endtask

  task automatic wait_proc(input string tag);
    int k = 0;
    while (bus.proc_en !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_proc_en"},    32'(bus.proc_en),  1);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic finish_proc(input string tag);
    bus.filt_finish = 1'b1;
    tick();
    bus.filt_finish = 1'b0;
    @(negedge clk);
    check({tag, "_fin_proc_en"}, 32'(bus.proc_en), 0);
    check({tag, "_fin_done"},    32'(bus.done),    1);
    check({tag, "_fin_busy"},    32'(bus.busy),    0);
  endtask

  task automatic wait_pixel(input string tag, input logic [SIZE-1:0] val);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.pix_valid === 1'b1 && bus.pix_out === val) && k < 50);
    check({tag, "_seen"}, 32'(bus.pix_out), 32'(val));
  endtask

  // Scoreboard: every accepted pixel is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_proc_exclusive", 32'(bus.pix_valid & bus.proc_en), 0);
      if (bus.pix_valid && bus.pix_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL unexpected_pixel: observed %0d expected none", bus.pix_out);
        end else begin
          logic [SIZE-1:0] e;
          e = exp_q.pop_front();
          check("pix_out", 32'(bus.pix_out), 32'(e));
        end
      end
    end
  end

  initial begin
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.start       = 1'b0;
    bus.pix_ready   = 1'b1;
    bus.filt_finish = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load mem[i] = i + 10
    for (int i = 0; i < NPIX; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(i);
      bus.wr_data = 8'(i + 10);
      tick();
    end
    bus.wr_en = 1'b0;

    // Full frame with pix_ready held high: exact timing of the valid window
    push_frame();
    pulse_start();
    @(negedge clk);
    check("t1_first_gap_valid", 32'(bus.pix_valid), 0);
    check("t1_busy",            32'(bus.busy),      1);
    for (int c = 0; c < NPIX; c++) begin
      @(negedge clk);
      check("t1_valid_run", 32'(bus.pix_valid), 1);
    end
    @(negedge clk);
    check("t1_valid_drop", 32'(bus.pix_valid),  0);
    check("t1_proc_rise",  32'(bus.proc_en),    1);
    check("t1_queue_left", 32'(exp_q.size()),   0);

    // PROCESS held while filt_finish stays low
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      check("t3_proc_hold", 32'(bus.proc_en), 1);
      check("t3_done_low",  32'(bus.done),    0);
    end
    finish_proc("t3");

    // Retransmit from DONE with a 3-cycle stall on pixel 14
    push_frame();
    pulse_start();
    wait_pixel("t2_pre_stall", 8'd13);
    @(posedge clk);
    #1 bus.pix_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t2_stall_pix",   32'(bus.pix_out),   14);
      check("t2_stall_valid", 32'(bus.pix_valid), 1);
      @(posedge clk);
      #1;
    end
    bus.pix_ready = 1'b1;
    wait_proc("t2");
    finish_proc("t2");

    // Write and start while busy are both ignored
    push_frame();
    pulse_start();
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(5);
    bus.wr_data = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check("t4_busy", 32'(bus.busy), 1);
    wait_proc("t4");
    finish_proc("t4");

    // Asynchronous reset in the middle of a frame
    push_frame();
    pulse_start();
    wait_pixel("t5_pre_reset", 8'd17);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("t5_idle");

    // Out-of-range writes in IDLE (16 would alias to entry 0 if not rejected)
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(12);
    bus.wr_data = 8'h55;
    tick();
    bus.wr_addr = ADDR_W'(16);
    bus.wr_data = 8'h66;
    tick();
    bus.wr_en = 1'b0;

    push_frame();
    pulse_start();
    wait_proc("t5");
    finish_proc("t5");

    // Four full frames plus 10..17 before the reset
    check("total_pixels", 32'(n_acc), 32'(4 * NPIX + 8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
